// File: rtl/simd_acc_seq_pkg.sv
// simd_acc_seq_pkg: shared state encoding and saturation constants for the accumulation controller
package simd_acc_seq_pkg;
    localparam int ACC_W = 32;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MAX_NEG = {1'b1, {(ACC_W-1){1'b0}}};
endpackage

// File: rtl/simd_acc_sat.sv
// simd_acc_sat: picks the next accumulator value, clamping on overflow when saturation is enabled
module simd_acc_sat
    import simd_acc_seq_pkg::*;
#(
    parameter int W        = ACC_W,
    parameter bit SATURATE = 1'b0
) (
    input  logic [W-1:0] s,
    input  logic         ovf,
    input  logic         neg,
    output logic [W-1:0] nxt
);
    // the true sign of the overflowed result selects which rail to clamp to
    always_comb nxt = (SATURATE && ovf) ? (neg ? MAX_NEG[W-1:0] : MAX_POS[W-1:0]) : s;
endmodule

// File: rtl/simd_acc_seq.sv
// simd_acc_seq: streams LEN operands through an external add/sub datapath and hands off the reduction
module simd_acc_seq
    import simd_acc_seq_pkg::*;
#(
    parameter int W        = ACC_W,
    parameter int CW       = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] len,
    input  logic          op_sub,
    input  logic [W-1:0]  din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [W-1:0]  add_a,
    output logic [W-1:0]  add_b,
    output logic          add_sub,
    input  logic [W-1:0]  add_s,
    input  logic          add_ovf,
    input  logic          add_neg,
    output logic [W-1:0]  result,
    output logic          ovf_sticky,
    output logic          neg_flag,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy
);
    state_t        state, state_nxt;
    logic [W-1:0]  acc, acc_nxt;
    logic [CW-1:0] cnt;
    logic          op, beat;

    simd_acc_sat #(.W(W), .SATURATE(SATURATE)) u_sat (
        .s   (add_s),
        .ovf (add_ovf),
        .neg (add_neg),
        .nxt (acc_nxt)
    );

    assign add_a   = acc;
    assign add_b   = din;
    assign add_sub = op;
    assign result  = acc;

    // state register; reset abandons any partial reduction
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;

    // handshakes and next state; an empty reduction goes straight to DONE
    always_comb begin
        din_ready = state == ST_ACC;
        res_valid = state == ST_DONE;
        busy      = state != ST_IDLE;
        beat      = din_valid && din_ready;
        state_nxt = state == ST_IDLE ? (start ? (len != '0 ? ST_ACC : ST_DONE) : ST_IDLE)
                  : state == ST_ACC  ? (beat && cnt == CW'(1) ? ST_DONE : ST_ACC)
                  : state == ST_DONE ? (res_ready ? ST_IDLE : ST_DONE)
                  : ST_IDLE;
    end

    // accumulator, beat counter and flags; START clears them, each accepted beat advances them
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            acc        <= '0;
            cnt        <= '0;
            op         <= 1'b0;
            ovf_sticky <= 1'b0;
            neg_flag   <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            acc        <= '0;
            cnt        <= len;
            op         <= op_sub;
            ovf_sticky <= 1'b0;
            neg_flag   <= 1'b0;
        end else if (beat) begin
            acc        <= acc_nxt;
            cnt        <= cnt - CW'(1);
            ovf_sticky <= ovf_sticky | add_ovf;
            neg_flag   <= add_neg;
        end
endmodule
